// File: rtl/control_fsm_stall_pkg.sv
// Shared types for the stall-aware multicycle RV32I controller: opcodes, mux selects, states, trap causes.
package control_fsm_stall_pkg;

   typedef logic [31:0] data_t;

   typedef enum logic [6:0] {
      RType       = 7'b0110011,
      IType_logic = 7'b0010011,
      IType_load  = 7'b0000011,
      SType       = 7'b0100011,
      BType       = 7'b1100011,
      JType       = 7'b1101111,
      IType_jalr  = 7'b1100111,
      UType_lui   = 7'b0110111,
      UType_auipc = 7'b0010111,
      FENCE       = 7'b0001111
   } opcode_t;

   typedef enum logic       {ADR_PC, ADR_RESULT}                          adr_src_t;
   typedef enum logic       {PC_INCREMENT, PC_JUMP}                       pc_src_t;
   typedef enum logic [1:0] {SRCA_OLD_PC, SRCA_PC, SRCA_RS1, SRCA_ZERO}   alu_src_a_t;
   typedef enum logic [1:0] {SRCB_IMM_EXT, SRCB_RS2, SRCB_FOUR}           alu_src_b_t;
   typedef enum logic [1:0] {RES_ALU_OUT, RES_MEM_DATA, RES_ALU_RESULT}   result_src_t;

   typedef enum logic [4:0] {
      FETCH      = 5'd0,
      FETCH_WAIT = 5'd1,
      DECODE     = 5'd2,
      EXECUTER   = 5'd3,
      EXECUTEI   = 5'd4,
      UNCONDJUMP = 5'd5,
      LUI        = 5'd6,
      AUIPC      = 5'd7,
      JALR_CALC  = 5'd8,
      JALR_STEP2 = 5'd9,
      MEMADR     = 5'd10,
      MEMREAD    = 5'd11,
      MEMWB      = 5'd12,
      MEMWRITE   = 5'd13,
      BRANCHIFEQ = 5'd14,
      BRANCHCOMP = 5'd15,
      ALUWB      = 5'd16,
      TRAP       = 5'd17
   } ctrl_state_t;

   typedef enum logic [1:0] {
      TC_NONE        = 2'd0,
      TC_ILLEGAL_OP  = 2'd1,
      TC_ILLEGAL_BR  = 2'd2,
      TC_MEM_TIMEOUT = 2'd3
   } trap_cause_t;

   // States that hold a memory request open until mem_ready.
   function automatic logic is_wait_state(ctrl_state_t s);
      return s inside {FETCH_WAIT, MEMREAD, MEMWRITE};
   endfunction

endpackage

// File: rtl/control_fsm_stall_if.sv
// Controller <-> datapath/memory bundle; master is the controller, slave is the datapath and memory side.
interface control_fsm_stall_if;
   import control_fsm_stall_pkg::*;

   opcode_t     opcode;
   logic [2:0]  funct3;
   logic        zero_flag;
   data_t       alu_result;
   logic [3:0]  mem_byte_en;
   logic        mem_ready;

   logic        mem_req;
   adr_src_t    adr_src;
   pc_src_t     pc_src;
   alu_src_a_t  alu_src_a;
   alu_src_b_t  alu_src_b;
   result_src_t result_src;
   logic        ir_write;
   logic        reg_write;
   logic        pc_update;
   logic        branch;
   logic [3:0]  mem_write;
   logic        trap;
   trap_cause_t trap_cause;
   logic [4:0]  fsm_state;

   modport master (
      input  opcode, funct3, zero_flag, alu_result, mem_byte_en, mem_ready,
      output mem_req, adr_src, pc_src, alu_src_a, alu_src_b, result_src,
             ir_write, reg_write, pc_update, branch, mem_write, trap, trap_cause, fsm_state
   );

   modport slave (
      output opcode, funct3, zero_flag, alu_result, mem_byte_en, mem_ready,
      input  mem_req, adr_src, pc_src, alu_src_a, alu_src_b, result_src,
             ir_write, reg_write, pc_update, branch, mem_write, trap, trap_cause, fsm_state
   );

endinterface

// File: rtl/control_fsm_stall_mem_wait_timer.sv
// Saturating count of consecutive memory wait cycles; o_expired flags the cycle whose
// wait would bring the count to TIMEOUT_CYCLES.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_cnt_en,
   input  logic i_clr,
   output logic o_expired
);
   localparam int unsigned       TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  LP_MAX  = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0]  LP_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_cnt_en && (r_count != LP_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = i_cnt_en && (r_count >= LP_LAST);

endmodule

// File: rtl/control_fsm_stall.sv
// Multicycle RV32I controller that stalls fetch/load/store on mem_ready and halts in TRAP on bad encodings.
// Optional memory timeout trap is built when CONTROL_FSM_TIMEOUT_EN is defined.
module control_fsm_stall
   import control_fsm_stall_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                reset,
   control_fsm_stall_if.master bus
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   ctrl_state_t r_state, w_next_state;
   trap_cause_t r_trap_cause, w_next_cause;
   logic        w_tmo_expired;
   logic        w_in_wait;

   logic        r_mem_req, r_reg_write, r_branch, r_trap;
   logic [3:0]  r_mem_write;
   adr_src_t    r_adr_src;
   alu_src_a_t  r_alu_src_a, w_alu_src_a;
   alu_src_b_t  r_alu_src_b, w_alu_src_b;
   result_src_t r_result_src, w_result_src;
   logic        w_ir_write, w_pc_update;
   pc_src_t     w_pc_src;
   logic        w_unused_alu;

   assign w_in_wait    = is_wait_state(r_state);
   assign w_unused_alu = ^bus.alu_result[31:1];

`ifdef CONTROL_FSM_TIMEOUT_EN
   mem_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_mem_wait_timer (
      .i_clk     (clk),
      .i_rst_n   (reset),
      .i_cnt_en  (w_in_wait && !bus.mem_ready),
      .i_clr     (!w_in_wait || bus.mem_ready),
      .o_expired (w_tmo_expired)
   );
`else
   assign w_tmo_expired = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      w_next_cause = r_trap_cause;
      case (r_state)
         FETCH:      w_next_state = FETCH_WAIT;
         FETCH_WAIT, MEMREAD, MEMWRITE: begin
            if (bus.mem_ready) begin
               w_next_state = (r_state == FETCH_WAIT) ? DECODE :
                              (r_state == MEMREAD)    ? MEMWB  : FETCH;
            end else if (w_tmo_expired) begin
               w_next_state = TRAP;
               w_next_cause = TC_MEM_TIMEOUT;
            end
         end
         DECODE: begin
            case (bus.opcode)
               JType:              w_next_state = UNCONDJUMP;
               RType:              w_next_state = EXECUTER;
               IType_logic:        w_next_state = EXECUTEI;
               IType_load, SType:  w_next_state = MEMADR;
               UType_auipc:        w_next_state = AUIPC;
               UType_lui:          w_next_state = LUI;
               IType_jalr:         w_next_state = JALR_CALC;
               FENCE:              w_next_state = FETCH;
               BType: begin
                  case (bus.funct3)
                     3'b000, 3'b001: w_next_state = BRANCHIFEQ;
                     3'b010, 3'b011: begin
                        w_next_state = TRAP;
                        w_next_cause = TC_ILLEGAL_BR;
                     end
                     default:        w_next_state = BRANCHCOMP;
                  endcase
               end
               default: begin
                  w_next_state = TRAP;
                  w_next_cause = TC_ILLEGAL_OP;
               end
            endcase
         end
         EXECUTER, EXECUTEI, UNCONDJUMP, LUI, AUIPC, JALR_STEP2: w_next_state = ALUWB;
         JALR_CALC:  w_next_state = JALR_STEP2;
         MEMADR:     w_next_state = (bus.opcode == IType_load) ? MEMREAD : MEMWRITE;
         MEMWB, ALUWB, BRANCHIFEQ, BRANCHCOMP: w_next_state = FETCH;
         TRAP:       w_next_state = TRAP;
         default:    w_next_state = FETCH;
      endcase
   end

   // Datapath selects decoded from the state being entered, so they register in step with r_state.
   always_comb begin
      w_alu_src_a  = SRCA_OLD_PC;
      w_alu_src_b  = SRCB_IMM_EXT;
      w_result_src = RES_ALU_OUT;
      case (w_next_state)
         FETCH_WAIT: begin
            w_alu_src_a  = SRCA_PC;
            w_alu_src_b  = SRCB_FOUR;
            w_result_src = RES_ALU_RESULT;
         end
         EXECUTER, BRANCHIFEQ, BRANCHCOMP: begin
            w_alu_src_a = SRCA_RS1;
            w_alu_src_b = SRCB_RS2;
         end
         EXECUTEI, MEMADR, JALR_CALC: w_alu_src_a = SRCA_RS1;
         UNCONDJUMP, JALR_STEP2:     w_alu_src_b = SRCB_FOUR;
         LUI:                        w_alu_src_a = SRCA_ZERO;
         MEMWB:                      w_result_src = RES_MEM_DATA;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= FETCH;
         r_trap_cause <= TC_NONE;
         r_mem_req    <= 1'b0;
         r_adr_src    <= ADR_PC;
         r_mem_write  <= 4'b0000;
         r_reg_write  <= 1'b0;
         r_branch     <= 1'b0;
         r_trap       <= 1'b0;
         r_alu_src_a  <= SRCA_OLD_PC;
         r_alu_src_b  <= SRCB_IMM_EXT;
         r_result_src <= RES_ALU_OUT;
      end else begin
         r_state      <= w_next_state;
         r_trap_cause <= w_next_cause;
         r_mem_req    <= is_wait_state(w_next_state);
         r_adr_src    <= (w_next_state inside {MEMREAD, MEMWRITE}) ? ADR_RESULT : ADR_PC;
         // Byte strobes are captured once on entry so they cannot change while the store waits.
         if (w_next_state != MEMWRITE) begin
            r_mem_write <= 4'b0000;
         end else if (r_state != MEMWRITE) begin
            r_mem_write <= bus.mem_byte_en;
         end
         r_reg_write  <= w_next_state inside {ALUWB, MEMWB};
         r_branch     <= w_next_state inside {BRANCHIFEQ, BRANCHCOMP};
         r_trap       <= (w_next_state == TRAP);
         r_alu_src_a  <= w_alu_src_a;
         r_alu_src_b  <= w_alu_src_b;
         r_result_src <= w_result_src;
      end
   end

   // Strobes that depend on this cycle's acknowledge or branch outcome.
   always_comb begin
      w_ir_write  = 1'b0;
      w_pc_update = 1'b0;
      w_pc_src    = PC_INCREMENT;
      case (r_state)
         FETCH_WAIT: begin
            w_ir_write  = bus.mem_ready;
            w_pc_update = bus.mem_ready;
         end
         UNCONDJUMP, JALR_STEP2: begin
            w_pc_update = 1'b1;
            w_pc_src    = PC_JUMP;
         end
         BRANCHIFEQ: begin
            if (bus.funct3[0] ? !bus.zero_flag : bus.zero_flag) begin
               w_pc_update = 1'b1;
               w_pc_src    = PC_JUMP;
            end
         end
         BRANCHCOMP: begin
            if (bus.alu_result[0]) begin
               w_pc_update = 1'b1;
               w_pc_src    = PC_JUMP;
            end
         end
         default: ;
      endcase
   end

   assign bus.mem_req    = r_mem_req;
   assign bus.adr_src    = r_adr_src;
   assign bus.mem_write  = r_mem_write;
   assign bus.pc_src     = w_pc_src;
   assign bus.alu_src_a  = r_alu_src_a;
   assign bus.alu_src_b  = r_alu_src_b;
   assign bus.result_src = r_result_src;
   assign bus.ir_write   = w_ir_write;
   assign bus.reg_write  = r_reg_write;
   assign bus.pc_update  = w_pc_update;
   assign bus.branch     = r_branch;
   assign bus.trap       = r_trap;
   assign bus.trap_cause = r_trap_cause;
   assign bus.fsm_state  = r_state;

endmodule

// File: tb/tb_control_fsm_stall.sv
// Directed bench for control_fsm_stall (TIMEOUT_CYCLES=4); timeout scenario follows CONTROL_FSM_TIMEOUT_EN.
module tb_control_fsm_stall;
   import control_fsm_stall_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   control_fsm_stall_if bus_if ();

   control_fsm_stall #(.TIMEOUT_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset low across one edge and release just after it, leaving the FSM in FETCH.
   task automatic pulse_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_if.opcode      = RType;
      bus_if.funct3      = 3'b000;
      bus_if.zero_flag   = 1'b0;
      bus_if.alu_result  = '0;
      bus_if.mem_byte_en = 4'b0000;
      bus_if.mem_ready   = 1'b0;
      #1 reset = 1'b0;
      #1;
      checks++; if (bus_if.fsm_state !== 5'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus_if.fsm_state); end
      checks++; if (bus_if.mem_req !== 1'b0 || bus_if.mem_write !== 4'b0000) begin errors++; $display("FAIL reset_mem got req=%b wr=%b want 0/0000", bus_if.mem_req, bus_if.mem_write); end
      checks++; if ({bus_if.ir_write, bus_if.reg_write, bus_if.pc_update, bus_if.branch} !== 4'b0000) begin errors++; $display("FAIL reset_enables got %b want 0000", {bus_if.ir_write, bus_if.reg_write, bus_if.pc_update, bus_if.branch}); end
      checks++; if (bus_if.adr_src !== ADR_PC || bus_if.pc_src !== PC_INCREMENT || bus_if.result_src !== RES_ALU_OUT) begin errors++; $display("FAIL reset_selects got adr=%0d pc=%0d res=%0d want 0/0/0", bus_if.adr_src, bus_if.pc_src, bus_if.result_src); end
      checks++; if (bus_if.alu_src_a !== SRCA_OLD_PC || bus_if.alu_src_b !== SRCB_IMM_EXT) begin errors++; $display("FAIL reset_alu_src got a=%0d b=%0d want 0/0", bus_if.alu_src_a, bus_if.alu_src_b); end
      checks++; if (bus_if.trap !== 1'b0 || bus_if.trap_cause !== TC_NONE) begin errors++; $display("FAIL reset_trap got %b/%0d want 0/0", bus_if.trap, bus_if.trap_cause); end
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Instruction walks with mem_ready tied high; each row ends when the FSM is back in FETCH.
   task automatic test_latency();
      opcode_t ops [5] = '{RType, IType_load, IType_jalr, JType, UType_lui};
      int      seq [5][7] = '{'{0, 1, 2, 3, 16, 0, 0},
                              '{0, 1, 2, 10, 11, 12, 0},
                              '{0, 1, 2, 8, 9, 16, 0},
                              '{0, 1, 2, 5, 16, 0, 0},
                              '{0, 1, 2, 6, 16, 0, 0}};
      bus_if.mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus_if.opcode = ops[k];
         for (int i = 0; i < 7; i++) begin
            int st;
            st = seq[k][i];
            checks++; if (bus_if.fsm_state !== 5'(st)) begin errors++; $display("FAIL seq%0d_state step %0d got %0d want %0d", k, i, bus_if.fsm_state, st); end
            checks++; if (bus_if.reg_write !== (st == 12 || st == 16)) begin errors++; $display("FAIL seq%0d_reg_write step %0d got %b", k, i, bus_if.reg_write); end
            checks++; if (bus_if.pc_update !== (st == 1 || st == 5 || st == 9)) begin errors++; $display("FAIL seq%0d_pc_update step %0d got %b", k, i, bus_if.pc_update); end
            checks++; if (bus_if.mem_req !== (st == 1 || st == 11)) begin errors++; $display("FAIL seq%0d_mem_req step %0d got %b", k, i, bus_if.mem_req); end
            if (i > 0 && st == 0) break;
            tick();
         end
      end
   endtask

   task automatic test_fetch_wait();
      int pulses = 0;
      bus_if.opcode    = FENCE;
      bus_if.mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         bus_if.mem_ready = (i == 3);
         #1;
         checks++; if (bus_if.fsm_state !== 5'd1 || bus_if.mem_req !== 1'b1 || bus_if.adr_src !== ADR_PC) begin errors++; $display("FAIL fetch_wait_hold cycle %0d got st=%0d req=%b", i, bus_if.fsm_state, bus_if.mem_req); end
         checks++; if (bus_if.ir_write !== (i == 3) || bus_if.pc_update !== (i == 3)) begin errors++; $display("FAIL fetch_wait_strobe cycle %0d got ir=%b pcu=%b", i, bus_if.ir_write, bus_if.pc_update); end
         if (bus_if.ir_write === 1'b1) pulses++;
         tick();
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL fetch_wait_pulses got %0d want 1", pulses); end
      checks++; if (bus_if.fsm_state !== 5'd2) begin errors++; $display("FAIL fetch_wait_decode got %0d want 2", bus_if.fsm_state); end
      tick();
      checks++; if (bus_if.fsm_state !== 5'd0) begin errors++; $display("FAIL fence_to_fetch got %0d want 0", bus_if.fsm_state); end
   endtask

   task automatic test_store();
      bus_if.opcode      = SType;
      bus_if.mem_byte_en = 4'b0011;
      bus_if.mem_ready   = 1'b1;
      repeat (3) tick();
      checks++; if (bus_if.fsm_state !== 5'd10) begin errors++; $display("FAIL store_memadr got %0d want 10", bus_if.fsm_state); end
      bus_if.mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         bus_if.mem_ready = (i == 2);
         #1;
         checks++; if (bus_if.fsm_state !== 5'd13 || bus_if.mem_write !== 4'b0011) begin errors++; $display("FAIL store_hold cycle %0d got st=%0d wr=%b want 13/0011", i, bus_if.fsm_state, bus_if.mem_write); end
         checks++; if (bus_if.mem_req !== 1'b1 || bus_if.adr_src !== ADR_RESULT) begin errors++; $display("FAIL store_req cycle %0d got req=%b adr=%0d", i, bus_if.mem_req, bus_if.adr_src); end
         tick();
      end
      checks++; if (bus_if.fsm_state !== 5'd0 || bus_if.mem_write !== 4'b0000 || bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL store_done got st=%0d wr=%b req=%b", bus_if.fsm_state, bus_if.mem_write, bus_if.mem_req); end
   endtask

   task automatic test_branch();
      logic [2:0] f3  [4] = '{3'b000, 3'b001, 3'b100, 3'b111};
      logic       zf  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic       a0  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      int         est [4] = '{14, 14, 15, 15};
      logic       tkn [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      bus_if.opcode    = BType;
      bus_if.mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus_if.funct3     = f3[k];
         bus_if.zero_flag  = zf[k];
         bus_if.alu_result = {31'd0, a0[k]};
         repeat (3) tick();
         checks++; if (bus_if.fsm_state !== 5'(est[k]) || bus_if.branch !== 1'b1) begin errors++; $display("FAIL branch%0d_state got %0d/%b want %0d/1", k, bus_if.fsm_state, bus_if.branch, est[k]); end
         checks++; if (bus_if.pc_update !== tkn[k] || bus_if.pc_src !== (tkn[k] ? PC_JUMP : PC_INCREMENT)) begin errors++; $display("FAIL branch%0d_taken got pcu=%b src=%0d want %b", k, bus_if.pc_update, bus_if.pc_src, tkn[k]); end
         tick();
         checks++; if (bus_if.fsm_state !== 5'd0) begin errors++; $display("FAIL branch%0d_return got %0d want 0", k, bus_if.fsm_state); end
      end
   endtask

   task automatic test_illegal();
      opcode_t     op  [2];
      logic [2:0]  f3  [2] = '{3'b000, 3'b010};
      trap_cause_t tc  [2] = '{TC_ILLEGAL_OP, TC_ILLEGAL_BR};
      logic [6:0]  bad;
      bad    = 7'b1111111;
      op[0]  = opcode_t'(bad);
      op[1]  = BType;
      bus_if.mem_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         bus_if.opcode = op[k];
         bus_if.funct3 = f3[k];
         repeat (3) tick();
         checks++; if (bus_if.fsm_state !== 5'd17 || bus_if.trap !== 1'b1 || bus_if.trap_cause !== tc[k]) begin errors++; $display("FAIL illegal%0d_trap got st=%0d trap=%b cause=%0d want 17/1/%0d", k, bus_if.fsm_state, bus_if.trap, bus_if.trap_cause, tc[k]); end
         if (k == 0) begin
            for (int c = 0; c < 100; c++) begin
               bus_if.mem_ready = c[0];
               bus_if.opcode    = c[1] ? RType : op[0];
               tick();
               checks++;
               if (bus_if.fsm_state !== 5'd17 || bus_if.mem_req !== 1'b0 || bus_if.mem_write !== 4'b0000 ||
                   {bus_if.ir_write, bus_if.reg_write, bus_if.pc_update, bus_if.branch} !== 4'b0000 ||
                   bus_if.trap !== 1'b1 || bus_if.trap_cause !== TC_ILLEGAL_OP) begin
                  errors++; $display("FAIL trap_frozen cycle %0d got st=%0d req=%b cause=%0d", c, bus_if.fsm_state, bus_if.mem_req, bus_if.trap_cause);
               end
            end
         end
         reset = 1'b0;
         #1;
         checks++; if (bus_if.fsm_state !== 5'd0 || bus_if.trap !== 1'b0 || bus_if.trap_cause !== TC_NONE) begin errors++; $display("FAIL illegal%0d_reset got st=%0d trap=%b cause=%0d", k, bus_if.fsm_state, bus_if.trap, bus_if.trap_cause); end
         @(posedge clk);
         #1 reset = 1'b1;
         bus_if.mem_ready = 1'b1;
      end
   endtask

   task automatic test_timeout();
      bus_if.opcode    = RType;
      bus_if.mem_ready = 1'b0;
      tick();
`ifdef CONTROL_FSM_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus_if.fsm_state !== 5'd1) begin errors++; $display("FAIL timeout_wait cycle %0d got %0d want 1", i, bus_if.fsm_state); end
         tick();
      end
      checks++; if (bus_if.fsm_state !== 5'd17 || bus_if.trap_cause !== TC_MEM_TIMEOUT || bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL timeout_trap got st=%0d cause=%0d req=%b want 17/3/0", bus_if.fsm_state, bus_if.trap_cause, bus_if.mem_req); end
`else
      repeat (1000) tick();
      checks++; if (bus_if.fsm_state !== 5'd1 || bus_if.mem_req !== 1'b1 || bus_if.trap !== 1'b0) begin errors++; $display("FAIL no_timeout got st=%0d req=%b trap=%b want 1/1/0", bus_if.fsm_state, bus_if.mem_req, bus_if.trap); end
`endif
      pulse_reset();
   endtask

   task automatic test_reset_mid_wait();
      bus_if.opcode    = RType;
      bus_if.mem_ready = 1'b0;
      repeat (2) tick();
      checks++; if (bus_if.mem_req !== 1'b1) begin errors++; $display("FAIL midwait_req got %b want 1", bus_if.mem_req); end
      #1 reset = 1'b0;
      #1;
      checks++; if (bus_if.mem_req !== 1'b0 || bus_if.fsm_state !== 5'd0) begin errors++; $display("FAIL midwait_async got req=%b st=%0d want 0/0", bus_if.mem_req, bus_if.fsm_state); end
      @(posedge clk);
      #1 reset = 1'b1;
      bus_if.mem_ready = 1'b1;
      tick();
      checks++; if (bus_if.fsm_state !== 5'd1 || bus_if.ir_write !== 1'b1) begin errors++; $display("FAIL midwait_resume got st=%0d ir=%b want 1/1", bus_if.fsm_state, bus_if.ir_write); end
      bus_if.opcode      = SType;
      bus_if.mem_byte_en = 4'b1100;
      repeat (3) tick();
      bus_if.mem_ready = 1'b0;
      tick();
      checks++; if (bus_if.fsm_state !== 5'd13 || bus_if.mem_write !== 4'b1100) begin errors++; $display("FAIL midstore_strobe got st=%0d wr=%b want 13/1100", bus_if.fsm_state, bus_if.mem_write); end
      #2 reset = 1'b0;
      #1;
      checks++; if (bus_if.mem_write !== 4'b0000 || bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL midstore_async got wr=%b req=%b want 0000/0", bus_if.mem_write, bus_if.mem_req); end
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fetch_wait();
      test_store();
      test_branch();
      test_illegal();
      test_timeout();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
